// File: rtl/exec_pkg.sv
// Shared types and constants for the Execute->Memory stage: condition codes,
// NZCV bit positions and the packed Memory-stage control payload.
package exec_pkg;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned RD_W    = 4;

    localparam int unsigned N_B = 3;
    localparam int unsigned Z_B = 2;
    localparam int unsigned C_B = 1;
    localparam int unsigned V_B = 0;

    typedef enum logic [COND_W-1:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic            valid;
        logic            pcsrc;
        logic            regwrite;
        logic            memtoreg;
        logic            memwrite;
        logic [RD_W-1:0] rd;
    } m_ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation: condition field against the
// architectural NZCV flags.
module cond_check
    import exec_pkg::*;
(
    input  logic [COND_W-1:0]  cond_i,
    input  logic [FLAGS_W-1:0] flags_i,
    output logic               cond_ex_o
);

    logic n, z, c, v;

    always_comb begin
        n = flags_i[N_B];
        z = flags_i[Z_B];
        c = flags_i[C_B];
        v = flags_i[V_B];
        cond_ex_o = 1'b1;
        case (cond_e'(cond_i))
            EQ:      cond_ex_o = z;
            NE:      cond_ex_o = !z;
            CS:      cond_ex_o = c;
            CC:      cond_ex_o = !c;
            MI:      cond_ex_o = n;
            PL:      cond_ex_o = !n;
            VS:      cond_ex_o = v;
            VC:      cond_ex_o = !v;
            HI:      cond_ex_o = c & !z;
            LS:      cond_ex_o = !c | z;
            GE:      cond_ex_o = (n == v);
            LT:      cond_ex_o = (n != v);
            GT:      cond_ex_o = !z & (n == v);
            LE:      cond_ex_o = z | (n != v);
            default: cond_ex_o = 1'b1;  // AL and the 1111 encoding always execute
        endcase
    end

endmodule

// File: rtl/exec_mem_stage.sv
// Execute-side condition check, NZCV register and Execute->Memory pipeline register.
// Optional EXEC_SQUASH_CNT_EN adds squash_cnt, a count of condition-failed instructions.
module exec_mem_stage
    import exec_pkg::*;
#(
    parameter int unsigned         DW        = 32,
    parameter logic [FLAGS_W-1:0]  FLAGS_RST = 4'b0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                validE,
    input  logic                PCSrcE,
    input  logic                RegWriteE,
    input  logic                MemtoRegE,
    input  logic                MemWriteE,
    input  logic [1:0]          FlagWriteE,
    input  logic [COND_W-1:0]   CondE,
    input  logic [RD_W-1:0]     RdE,
    input  logic [FLAGS_W-1:0]  ALUFlagsE,
    input  logic [DW-1:0]       ALUResultE,
    input  logic [DW-1:0]       WriteDataE,
    input  logic                stallM,
    input  logic                flushM,
    output logic                CondExE,
    output logic                BranchTakenE,
    output logic [FLAGS_W-1:0]  FlagsQ,
    output logic                validM,
    output logic                PCSrcM,
    output logic                RegWriteM,
    output logic                MemtoRegM,
    output logic                MemWriteM,
    output logic [RD_W-1:0]     RdM,
    output logic [DW-1:0]       ALUResultM,
    output logic [DW-1:0]       WriteDataM
`ifdef EXEC_SQUASH_CNT_EN
    ,
    output logic [31:0]         squash_cnt
`endif
);

    logic               cond_pass;
    logic               advance;
    logic               exec_ok;
    m_ctrl_t            m_q, m_d;
    logic [DW-1:0]      alu_q, alu_d;
    logic [DW-1:0]      wd_q, wd_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;

    cond_check u_cond_check (
        .cond_i    (CondE),
        .flags_i   (flags_q),
        .cond_ex_o (cond_pass)
    );

    assign advance      = !stallM & !flushM;
    assign exec_ok      = validE & cond_pass;
    assign CondExE      = cond_pass;
    assign BranchTakenE = validE & PCSrcE & cond_pass;

    // Next state: flush beats stall beats advance; only surviving advances touch NZCV.
    always_comb begin
        m_d     = m_q;
        alu_d   = alu_q;
        wd_d    = wd_q;
        flags_d = flags_q;
        if (flushM) begin
            m_d.valid    = 1'b0;
            m_d.pcsrc    = 1'b0;
            m_d.regwrite = 1'b0;
            m_d.memtoreg = 1'b0;
            m_d.memwrite = 1'b0;
        end else if (advance) begin
            m_d.valid    = validE;
            m_d.pcsrc    = PCSrcE & exec_ok;
            m_d.regwrite = RegWriteE & exec_ok;
            m_d.memtoreg = MemtoRegE;
            m_d.memwrite = MemWriteE & exec_ok;
            m_d.rd       = RdE;
            alu_d        = ALUResultE;
            wd_d         = WriteDataE;
            if (exec_ok) begin
                if (FlagWriteE[1]) begin
                    flags_d[N_B] = ALUFlagsE[N_B];
                    flags_d[Z_B] = ALUFlagsE[Z_B];
                end
                if (FlagWriteE[0]) begin
                    flags_d[C_B] = ALUFlagsE[C_B];
                    flags_d[V_B] = ALUFlagsE[V_B];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q     <= '0;
            alu_q   <= '0;
            wd_q    <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            m_q     <= m_d;
            alu_q   <= alu_d;
            wd_q    <= wd_d;
            flags_q <= flags_d;
        end
    end

    assign FlagsQ     = flags_q;
    assign validM     = m_q.valid;
    assign PCSrcM     = m_q.pcsrc;
    assign RegWriteM  = m_q.regwrite;
    assign MemtoRegM  = m_q.memtoreg;
    assign MemWriteM  = m_q.memwrite;
    assign RdM        = m_q.rd;
    assign ALUResultM = alu_q;
    assign WriteDataM = wd_q;

`ifdef EXEC_SQUASH_CNT_EN
    logic [31:0] sq_q, sq_d;

    // Counts valid instructions annulled by a failed condition as they leave Execute.
    always_comb begin
        sq_d = sq_q;
        if (advance && validE && !cond_pass) begin
            sq_d = sq_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign squash_cnt = sq_q;
`else
    // Squash counter not built in this configuration.
`endif

endmodule
